// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: redirect input, instruction-memory req/gnt/rvalid
// handshake and the valid/ready decoder handshake.
// master: the fetch unit. slave: the surrounding core/memory/decoder.
interface fetch_unit_if;
  // Redirect from execute
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  // Instruction memory
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  // Decoder side
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] pc;

  modport master (
    input  redirect_valid,
    input  redirect_pc,
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata,
    output instr_valid,
    input  instr_ready,
    output instruction,
    output pc
  );

  modport slave (
    output redirect_valid,
    output redirect_pc,
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata,
    input  instr_valid,
    output instr_ready,
    input  instruction,
    input  pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues one outstanding word request
// at a time, buffers responses with their PC in a small prefetch FIFO and presents
// the FIFO head to the decoder. Redirects flush the FIFO and restart fetch.
// Optional stall counter output enabled by defining FETCH_PERF_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]  fetch_stall_cnt
`endif
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);
  localparam logic [31:0] ResetPcAligned = {RESET_PC[31:2], 2'b00};

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StDrop
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_pc_q, req_pc_d;

  // Prefetch buffer storage and bookkeeping
  logic [31:0]     fifo_instr_q [FIFO_DEPTH];
  logic [31:0]     fifo_pc_q    [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic        push;
  logic        pop;
  logic        instr_valid;
  logic [31:0] redirect_target;

  // Low two bits of the redirect target are don't-care
  logic unused_redirect_bits;
  assign unused_redirect_bits = ^bus.redirect_pc[1:0];

  assign redirect_target = {bus.redirect_pc[31:2], 2'b00};
  assign instr_valid     = (count_q != '0);

  // Redirect beats push and pop: stale data and the consumed head are both dropped
  assign push = (state_q == StWait) && bus.imem_rvalid && !bus.redirect_valid;
  assign pop  = instr_valid && bus.instr_ready && !bus.redirect_valid;

  // FIFO pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.redirect_valid) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  // FIFO pointer and occupancy registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage; reset to zero so the head reads 0 out of reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        fifo_instr_q[i] <= '0;
        fifo_pc_q[i]    <= '0;
      end
    end else if (push) begin
      fifo_instr_q[wr_ptr_q] <= bus.imem_rdata;
      fifo_pc_q[wr_ptr_q]    <= req_pc_q;
    end
  end

  // Fetch FSM next-state, fetch PC and request PC
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;

    unique case (state_q)
      StIdle: begin
        if (count_q < DepthCnt) begin
          state_d = StReq;
        end
      end
      StReq: begin
        if (bus.imem_gnt) begin
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = StWait;
        end
      end
      StWait: begin
        if (bus.imem_rvalid) begin
          state_d = (count_d < DepthCnt) ? StReq : StIdle;
        end
      end
      StDrop: begin
        if (bus.imem_rvalid) begin
          state_d = StReq;
        end
      end
      default: state_d = StIdle;
    endcase

    if (bus.redirect_valid) begin
      fetch_pc_d = redirect_target;
      // A response still owed by memory must be swallowed before refetching. If it
      // arrives in the redirect cycle itself, nothing is owed any more.
      if (((state_q == StWait) || (state_q == StDrop)) && !bus.imem_rvalid) begin
        state_d = StDrop;
      end else if ((state_q == StReq) && bus.imem_gnt) begin
        state_d = StDrop;
      end else begin
        state_d = StReq;
      end
    end
  end

  // Fetch FSM and PC registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      fetch_pc_q <= ResetPcAligned;
      req_pc_q   <= ResetPcAligned;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
    end
  end

  assign bus.imem_req    = (state_q == StReq);
  assign bus.imem_addr   = fetch_pc_q;
  assign bus.instr_valid = instr_valid;
  assign bus.instruction = fifo_instr_q[rd_ptr_q];
  assign bus.pc          = fifo_pc_q[rd_ptr_q];

`ifdef FETCH_PERF_EN
  logic [31:0] stall_cnt_q;

  // Count cycles where the decoder is ready but has nothing to take
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (bus.instr_ready && !instr_valid) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign fetch_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit. Memory and decoder are driven cycle by cycle;
// outputs are sampled 1 time unit after each rising edge.
module tb_fetch_unit;

  logic clk;
  logic reset;
  int   n_total;
  int   n_pass;

  fetch_unit_if bus_if ();

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_stall_cnt;
`endif

  fetch_unit #(
    .RESET_PC   (32'h0000_0102),
    .FIFO_DEPTH (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.master)
`ifdef FETCH_PERF_EN
    ,
    .fetch_stall_cnt (fetch_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic drive(input logic gnt, input logic rvalid, input logic [31:0] rdata,
                       input logic ready);
    bus_if.imem_gnt    = gnt;
    bus_if.imem_rvalid = rvalid;
    bus_if.imem_rdata  = rdata;
    bus_if.instr_ready = ready;
  endtask

  task automatic redirect(input logic v, input logic [31:0] target);
    bus_if.redirect_valid = v;
    bus_if.redirect_pc    = target;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    reset   = 1'b1;
    redirect(1'b0, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b0);

    // Reset state
    tick();
    tick();
    check("rst_req",   32'(bus_if.imem_req), 32'd0);
    check("rst_addr",  bus_if.imem_addr, 32'h0000_0100);
    check("rst_valid", 32'(bus_if.instr_valid), 32'd0);
    check("rst_instr", bus_if.instruction, 32'h0);
    check("rst_pc",    bus_if.pc, 32'h0);

    reset = 1'b0;
    tick();
    check("boot_req",  32'(bus_if.imem_req), 32'd1);
    check("boot_addr", bus_if.imem_addr, 32'h0000_0100);

    // Streaming: gnt immediately, rvalid next cycle, decoder always ready
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    tick();
    check("wait0_req",  32'(bus_if.imem_req), 32'd0);
    check("wait0_addr", bus_if.imem_addr, 32'h0000_0104);
    drive(1'b0, 1'b1, 32'h0000_0093, 1'b1);
    tick();
    check("i0_valid", 32'(bus_if.instr_valid), 32'd1);
    check("i0_instr", bus_if.instruction, 32'h0000_0093);
    check("i0_pc",    bus_if.pc, 32'h0000_0100);
    check("i0_req",   32'(bus_if.imem_req), 32'd1);
    check("i0_addr",  bus_if.imem_addr, 32'h0000_0104);
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    tick();
    check("gap_valid", 32'(bus_if.instr_valid), 32'd0);
    drive(1'b0, 1'b1, 32'h0010_0113, 1'b1);
    tick();
    check("i1_valid", 32'(bus_if.instr_valid), 32'd1);
    check("i1_instr", bus_if.instruction, 32'h0010_0113);
    check("i1_pc",    bus_if.pc, 32'h0000_0104);
    check("i1_addr",  bus_if.imem_addr, 32'h0000_0108);

    // Back-pressure: decoder stalls for 10 cycles, FIFO fills
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 32'h0020_0193, 1'b0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("full_req", 32'(bus_if.imem_req), 32'd0);
    end
    check("full_head_pc",    bus_if.pc, 32'h0000_0104);
    check("full_head_instr", bus_if.instruction, 32'h0010_0113);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    check("drain1_valid", 32'(bus_if.instr_valid), 32'd1);
    check("drain1_instr", bus_if.instruction, 32'h0020_0193);
    check("drain1_pc",    bus_if.pc, 32'h0000_0108);
    tick();
    check("drain2_valid", 32'(bus_if.instr_valid), 32'd0);
    check("resume_req",   32'(bus_if.imem_req), 32'd1);
    check("resume_addr",  bus_if.imem_addr, 32'h0000_010C);

    // Redirect while waiting for a response; stale word must vanish
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    redirect(1'b1, 32'h0000_2003);
    tick();
    redirect(1'b0, 32'h0);
    check("drop_req",  32'(bus_if.imem_req), 32'd0);
    check("drop_addr", bus_if.imem_addr, 32'h0000_2000);
    drive(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
    tick();
    check("stale_valid", 32'(bus_if.instr_valid), 32'd0);
    check("tgt_req",     32'(bus_if.imem_req), 32'd1);
    check("tgt_addr",    bus_if.imem_addr, 32'h0000_2000);
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    tick();
    drive(1'b0, 1'b1, 32'h0000_0013, 1'b1);
    tick();
    check("tgt_valid", 32'(bus_if.instr_valid), 32'd1);
    check("tgt_pc",    bus_if.pc, 32'h0000_2000);
    check("tgt_instr", bus_if.instruction, 32'h0000_0013);

    // Redirect coinciding with a pop and a response
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 32'hBAD0_0013, 1'b1);
    redirect(1'b1, 32'h0000_3000);
    tick();
    redirect(1'b0, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    check("coll_valid", 32'(bus_if.instr_valid), 32'd0);
    check("coll_req",   32'(bus_if.imem_req), 32'd1);
    check("coll_addr",  bus_if.imem_addr, 32'h0000_3000);
    tick();
    check("coll_valid2", 32'(bus_if.instr_valid), 32'd0);
    check("coll_hold",   bus_if.imem_addr, 32'h0000_3000);

    // PC wrap at the top of the address space
    redirect(1'b1, 32'hFFFF_FFFF);
    tick();
    redirect(1'b0, 32'h0);
    check("top_addr", bus_if.imem_addr, 32'hFFFF_FFFC);
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    check("wrap_addr", bus_if.imem_addr, 32'h0000_0000);
    drive(1'b0, 1'b1, 32'h1234_5678, 1'b0);
    tick();
    check("wrap_pc",    bus_if.pc, 32'hFFFF_FFFC);
    check("wrap_instr", bus_if.instruction, 32'h1234_5678);
    check("wrap_req",   32'(bus_if.imem_req), 32'd1);

    // Redirect in the same cycle as a grant: the granted response is dropped
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    redirect(1'b1, 32'h0000_4000);
    tick();
    redirect(1'b0, 32'h0);
    check("gdrop_valid", 32'(bus_if.instr_valid), 32'd0);
    check("gdrop_req",   32'(bus_if.imem_req), 32'd0);
    check("gdrop_addr",  bus_if.imem_addr, 32'h0000_4000);
    drive(1'b0, 1'b1, 32'hCAFE_0000, 1'b0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    check("gdrop_valid2", 32'(bus_if.instr_valid), 32'd0);
    check("gdrop_req2",   32'(bus_if.imem_req), 32'd1);

    // Asynchronous reset mid-transaction
    reset = 1'b1;
    #1;
    check("arst_req",  32'(bus_if.imem_req), 32'd0);
    check("arst_addr", bus_if.imem_addr, 32'h0000_0100);
    tick();
`ifdef FETCH_PERF_EN
    check("perf_rst", fetch_stall_cnt, 32'd0);
`endif
    // Late responses after reset must be ignored; decoder starved for 5 cycles
    reset = 1'b0;
    drive(1'b0, 1'b1, 32'hFEED_0001, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("late_valid", 32'(bus_if.instr_valid), 32'd0);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    check("late_req",  32'(bus_if.imem_req), 32'd1);
    check("late_addr", bus_if.imem_addr, 32'h0000_0100);
`ifdef FETCH_PERF_EN
    check("perf_cnt", fetch_stall_cnt, 32'd5);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
